pipe_result_collector: RTL and testbench

PIPE_RESULT_COLLECTOR -- requirements
Module: pipe_result_collector

---
 rtl/pipe_result_collector.sv | 135 +++++++++++++
 tb/tb_pipe_result_collector.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_result_collector.sv
// ---------------------------------------------------------------------------
// pipe_result_collector
//
// Collects results from a fixed-latency, non-stallable producer pipeline.
// Upstream may only launch an operation while a credit is held. Each
// launched operation's result is later parked in a DEPTH-entry FIFO until
// the consumer takes it. Credits are returned when a result leaves.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics. A
// transfer (pop) happens on a rising edge where out_valid and out_ready
// are both high. out_valid never depends on out_ready. res_valid has no
// ready; an arrival is always taken unless the buffer is full with no
// pop. issue is qualified only by issue_ok.
//
// Optional feature macro: PIPE_RESULT_COLLECTOR_BYPASS_EN
//   When it is defined, an arrival into an empty buffer is presented on
//   the output in the same cycle. When it is undefined, an arrival first
//   shows on the output on the cycle after it is stored.
//
// Parameters
//   n      result data width
//   DEPTH  buffer entries and credit pool size (power of two, >= 2)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   gwe        global write enable; while low, no state is updated
//   issue      upstream launches one operation this cycle
//   issue_ok   a credit is available
//   res_valid  result arriving from the pipeline tail
//   res_data   arriving result value
//   out_valid  head result available
//   out_data   head result value (0 while nothing is available)
//   out_ready  consumer accepts the head result
//   err        sticky protocol-violation flag
//   count      current buffer occupancy
// ---------------------------------------------------------------------------
module pipe_result_collector #(
   parameter int n     = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     gwe,
   input  logic                     issue,
   output logic                     issue_ok,
   input  logic                     res_valid,
   input  logic [n-1:0]             res_data,
   output logic                     out_valid,
   output logic [n-1:0]             out_data,
   input  logic                     out_ready,
   output logic                     err,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [AW:0]   credits_q, credits_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic          err_q, err_d;
   logic [n-1:0]  mem [DEPTH];

   logic empty, full;
   logic pop, pop_fifo, push, drop, bypass;
   logic issue_acc, issue_bad;

   always_comb begin
      empty = (cnt_q == '0);
      full  = (cnt_q == DEPTH_C);

`ifdef PIPE_RESULT_COLLECTOR_BYPASS_EN
      // An arrival into an empty buffer is shown directly. The rst term
      // keeps out_valid low during reset even if res_valid is high.
      out_valid = !empty || (res_valid && rst);
      if (!empty)
         out_data = mem[rd_ptr_q];
      else if (res_valid && rst)
         out_data = res_data;
      else
         out_data = '0;
      bypass = empty && res_valid && out_ready;
`else
      out_valid = !empty;
      out_data  = empty ? '0 : mem[rd_ptr_q];
      bypass    = 1'b0;
`endif

      issue_ok  = (credits_q != '0);
      pop       = out_valid && out_ready;
      // A storage read happens only when the head comes from the FIFO.
      pop_fifo  = out_ready && !empty;
      // When the buffer is full, an arrival is accepted only together with
      // a pop. The write then lands in the slot being vacated.
      push      = res_valid && !bypass && (!full || pop_fifo);
      drop      = res_valid && full && !pop_fifo;
      issue_acc = issue && issue_ok;
      issue_bad = issue && !issue_ok;

      credits_d = credits_q + {{AW{1'b0}}, pop} - {{AW{1'b0}}, issue_acc};
      cnt_d     = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop_fifo};
      err_d     = err_q || issue_bad || drop;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credits_q <= DEPTH_C;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         err_q     <= 1'b0;
      end else if (gwe) begin
         credits_q <= credits_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         // Pointers wrap naturally because DEPTH is a power of two.
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_fifo)
            rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset. Stale entries are never visible because
   // out_data is forced to 0 while the buffer is empty.
   always_ff @(posedge clk) begin
      if (gwe && push)
         mem[wr_ptr_q] <= res_data;
   end

   assign err   = err_q;
   assign count = cnt_q;

endmodule

// File: tb/tb_pipe_result_collector.sv
module tb_pipe_result_collector;

  localparam int N = 16;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          gwe;
  logic          issue;
  logic          issue_ok;
  logic          res_valid;
  logic [N-1:0]  res_data;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic          out_ready;
  logic          err;
  logic [3:0]    count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] exp_q[$];

  typedef struct {
    logic          gwe;
    logic          issue;
    logic          res_valid;
    logic [N-1:0]  res_data;
    logic          out_ready;
    logic          e_ok;
    logic          e_ov;
    logic [N-1:0]  e_od;
    logic          e_err;
    logic [3:0]    e_cnt;
  } vec_t;

  vec_t vt[29];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_result_collector #(.n(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .gwe(gwe), .issue(issue), .issue_ok(issue_ok),
    .res_valid(res_valid), .res_data(res_data), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .err(err), .count(count)
  );

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge. Outputs are sampled 1 time unit later.
  // This is the state that the next rising edge will act upon.
  task automatic drive(input logic g, input logic i, input logic rv,
                       input logic [N-1:0] rd, input logic orr);
    @(negedge clk);
    gwe = g; issue = i; res_valid = rv; res_data = rd; out_ready = orr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; gwe = 1'b1; issue = 1'b0; res_valid = 1'b0;
    res_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic g, input logic i, input logic rv,
                              input logic [N-1:0] rd, input logic orr,
                              input logic ok, input logic ov,
                              input logic [N-1:0] od, input logic e,
                              input logic [3:0] c);
    vec_t v;
    v.gwe = g; v.issue = i; v.res_valid = rv; v.res_data = rd;
    v.out_ready = orr; v.e_ok = ok; v.e_ov = ov; v.e_od = od;
    v.e_err = e; v.e_cnt = c;
    return v;
  endfunction

  // Pops k entries and compares each one against the scoreboard head.
  task automatic drain(input string tag, input int k);
    for (int j = 0; j < k; j++) begin
      drive(1, 0, 0, '0, 1);
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".data"}, 32'(out_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    drive(1, 0, 0, '0, 0);
    chk({tag, ".empty_cnt"}, 32'(count), 32'd0);
    chk({tag, ".empty_ov"}, 32'(out_valid), 32'd0);
  endtask

  // Each issue must be accepted. After 'k' of them, issue_ok must be low.
  task automatic spend_credits(input string tag, input int k);
    for (int j = 0; j < k; j++) begin
      drive(1, 1, 0, '0, 0);
      chk($sformatf("%s.ok%0d", tag, j), 32'(issue_ok), 32'd1);
    end
    drive(1, 0, 0, '0, 0);
    chk({tag, ".ok_low"}, 32'(issue_ok), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1; gwe = 1'b1; issue = 1'b0; res_valid = 1'b0;
    res_data = '0; out_ready = 1'b0;

    // Table: 8 issues plus one illegal issue, 8 arrivals held, then 8 pops.
    vt[0] = mk(1, 0, 0, '0, 0, 1, 0, '0, 0, 4'd0);
    for (int k = 1; k <= 8; k++)
      vt[k] = mk(1, 1, 0, '0, 0, 1, 0, '0, 0, 4'd0);
    vt[9]  = mk(1, 1, 0, '0, 0, 0, 0, '0, 0, 4'd0);
    vt[10] = mk(1, 0, 0, '0, 0, 0, 0, '0, 1, 4'd0);
    for (int k = 1; k <= 8; k++)
      vt[10+k] = mk(1, 0, 1, 16'(k), 0, 0, (k > 1), (k > 1) ? 16'h1 : 16'h0,
                    1, 4'(k-1));
    vt[19] = mk(1, 0, 0, '0, 0, 0, 1, 16'h1, 1, 4'd8);
    for (int j = 0; j < 8; j++)
      vt[20+j] = mk(1, 0, 0, '0, 1, (j > 0), 1, 16'(j+1), 1, 4'(8-j));
    vt[28] = mk(1, 0, 0, '0, 0, 1, 0, '0, 1, 4'd0);

    // Asynchronous reset: the outputs clear before any clock edge.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.ov", 32'(out_valid), 32'd0);
    chk("rst.ok", 32'(issue_ok), 32'd1);
    chk("rst.cnt", 32'(count), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.od", 32'(out_data), 32'd0);
    do_reset();

    for (int i = 0; i < 29; i++) begin
      drive(vt[i].gwe, vt[i].issue, vt[i].res_valid, vt[i].res_data,
            vt[i].out_ready);
      chk($sformatf("v%0d.ok", i), 32'(issue_ok), 32'(vt[i].e_ok));
      chk($sformatf("v%0d.ov", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("v%0d.od", i), 32'(out_data), 32'(vt[i].e_od));
      chk($sformatf("v%0d.err", i), 32'(err), 32'(vt[i].e_err));
      chk($sformatf("v%0d.cnt", i), 32'(count), 32'(vt[i].e_cnt));
    end

    // Steady issue, arrival and pop at occupancy 4, across pointer wrap.
    do_reset();
    for (int k = 0; k < 4; k++) drive(1, 1, 0, '0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1, 16'h100 + 16'(k), 0);
      exp_q.push_back(16'h100 + 16'(k));
    end
    for (int c = 0; c < 20; c++) begin
      drive(1, 1, 1, 16'h200 + 16'(c), 1);
      chk($sformatf("st%0d.cnt", c), 32'(count), 32'd4);
      chk($sformatf("st%0d.data", c), 32'(out_data), 32'(exp_q[0]));
      chk($sformatf("st%0d.ok", c), 32'(issue_ok), 32'd1);
      void'(exp_q.pop_front());
      exp_q.push_back(16'h200 + 16'(c));
    end
    drive(1, 0, 0, '0, 0);
    chk("st.err", 32'(err), 32'd0);
    chk("st.cnt_end", 32'(count), 32'd4);
    drain("st_drain", 4);

    // Full buffer: push with pop is accepted; push without pop is dropped.
    do_reset();
    for (int k = 0; k < 8; k++) drive(1, 1, 0, '0, 0);
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 1, 16'h10 + 16'(k), 0);
      exp_q.push_back(16'h10 + 16'(k));
    end
    drive(1, 0, 1, 16'h18, 1);
    chk("full_pp.cnt_pre", 32'(count), 32'd8);
    chk("full_pp.head", 32'(out_data), 32'h10);
    void'(exp_q.pop_front());
    exp_q.push_back(16'h18);
    drive(1, 1, 0, '0, 0);
    chk("full_pp.cnt", 32'(count), 32'd8);
    chk("full_pp.err", 32'(err), 32'd0);
    chk("full_pp.head2", 32'(out_data), 32'h11);
    drive(1, 0, 1, 16'h99, 0);
    drive(1, 0, 0, '0, 0);
    chk("full_drop.err", 32'(err), 32'd1);
    chk("full_drop.cnt", 32'(count), 32'd8);
    chk("full_drop.head", 32'(out_data), 32'h11);
    drain("full_drain", 8);
    spend_credits("full_cr", 8);

    // gwe low: issue, pop and arrival are all lost, and the state holds.
    do_reset();
    for (int k = 0; k < 3; k++) drive(1, 1, 0, '0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 16'h21 + 16'(k), 0);
      exp_q.push_back(16'h21 + 16'(k));
    end
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 1, 16'h77, 1);
      chk($sformatf("gwe%0d.cnt", c), 32'(count), 32'd3);
      chk($sformatf("gwe%0d.data", c), 32'(out_data), 32'h21);
    end
    drive(1, 0, 0, '0, 0);
    chk("gwe.cnt_after", 32'(count), 32'd3);
    chk("gwe.err", 32'(err), 32'd0);
    chk("gwe.data_after", 32'(out_data), 32'h21);
    drain("gwe_drain", 3);
    spend_credits("gwe_cr", 8);

    // Reset mid-stream with 5 entries buffered.
    do_reset();
    for (int k = 0; k < 5; k++) drive(1, 1, 0, '0, 0);
    for (int k = 0; k < 5; k++) drive(1, 0, 1, 16'h40 + 16'(k), 0);
    drive(1, 0, 0, '0, 0);
    chk("mid.cnt_pre", 32'(count), 32'd5);
    chk("mid.ok_pre", 32'(issue_ok), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid.ov", 32'(out_valid), 32'd0);
    chk("mid.ok", 32'(issue_ok), 32'd1);
    chk("mid.cnt", 32'(count), 32'd0);
    res_valid = 1'b1; res_data = 16'h55;
    @(negedge clk);
    @(negedge clk);
    res_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid.cnt_rel", 32'(count), 32'd0);
    chk("mid.ov_rel", 32'(out_valid), 32'd0);
    spend_credits("mid_cr", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
